// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared types and helpers for the clock/reset sequencer
package clk_rst_pkg;

    // Sequencer phases, in bring-up order
    typedef enum logic [2:0] {
        S_MMCM_RST  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam int DBG_CNT_W = 8;

    // Width of the shared cycle counter: it only ever counts up to (largest limit - 1)
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if ($clog2(m) < 1) return 1;
        return $clog2(m);
    endfunction

    // Debug counters stick at all-ones instead of wrapping back to a misleading small value
    function automatic logic [DBG_CNT_W-1:0] sat_inc8(input logic [DBG_CNT_W-1:0] v);
        return (v == {DBG_CNT_W{1'b1}}) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// rtl/sync_ff2.sv - two-flop synchronizer with synchronous active-high reset
module sync_ff2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a full cycle to settle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - MMCM reset/lock supervisor with ordered domain reset release
module clk_rst_sequencer
    import clk_rst_pkg::*;
#(
    parameter int MMCM_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 1000000,
    parameter int LOCK_STABLE     = 1024,
    parameter int STAGE_GAP       = 256,
    parameter int N_STAGES        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                locked,
    input  logic                soft_req,
    output logic                mmcm_resetn,
    output logic [N_STAGES-1:0] rst_stage,
    output logic                ready,
    output logic [7:0]          retry_cnt,
    output logic [7:0]          loss_cnt
);

    localparam int CNT_W = cnt_width(MMCM_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, STAGE_GAP);
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0]    C_MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    C_STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]    C_GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]    C_IDX_FIRST    = IDX_W'(1);
    localparam logic [IDX_W-1:0]    C_IDX_LAST     = IDX_W'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0] C_ALL_STAGES   = {N_STAGES{1'b1}};

    // Registered state
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [N_STAGES-1:0] r_stage;
    logic                r_ready;
    logic                r_mmcm_resetn;
    logic [7:0]          r_retry;
    logic [7:0]          r_loss;

    // Next-state values
    logic                w_lk_s;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [N_STAGES-1:0] w_stage_nxt;
    logic                w_ready_nxt;
    logic                w_mmcm_resetn_nxt;
    logic [7:0]          w_retry_nxt;
    logic [7:0]          w_loss_nxt;

    // locked comes from the MMCM with no timing relationship to clk
    sync_ff2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (locked),
        .o_q   (w_lk_s)
    );

    // State register: every output is a flop so domain resets never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_MMCM_RST;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage       <= C_ALL_STAGES;
            r_ready       <= 1'b0;
            r_mmcm_resetn <= 1'b0;
            r_retry       <= '0;
            r_loss        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_stage       <= w_stage_nxt;
            r_ready       <= w_ready_nxt;
            r_mmcm_resetn <= w_mmcm_resetn_nxt;
            r_retry       <= w_retry_nxt;
            r_loss        <= w_loss_nxt;
        end
    end

    // Next-state logic: the shared counter restarts on every phase change
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_stage_nxt = r_stage;
        w_ready_nxt = r_ready;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;

        case (r_state)
            S_MMCM_RST: begin
                w_stage_nxt = C_ALL_STAGES;
                w_ready_nxt = 1'b0;
                if (r_cnt == C_MMCM_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end

            S_WAIT_LOCK: begin
                if (w_lk_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_retry_nxt = sat_inc8(r_retry);
                    w_state_nxt = S_MMCM_RST;
                    w_cnt_nxt   = '0;
                end
            end

            S_STABLE: begin
                if (!w_lk_s) begin
                    // A single dropout restarts both the stability window and the timeout
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_cnt_nxt      = '0;
                    w_stage_nxt[0] = 1'b0;
                    if (N_STAGES == 1) begin
                        w_state_nxt = S_RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE;
                        w_idx_nxt   = C_IDX_FIRST;
                    end
                end
            end

            S_RELEASE, S_RUN: begin
                if (!w_lk_s) begin
                    // Lock loss outranks a concurrent software request
                    w_state_nxt = S_MMCM_RST;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_stage_nxt = C_ALL_STAGES;
                    w_ready_nxt = 1'b0;
                    w_loss_nxt  = sat_inc8(r_loss);
                end else if (soft_req) begin
                    // Software reset keeps the MMCM running and replays the release order from stage 0
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_stage_nxt = C_ALL_STAGES;
                    w_ready_nxt = 1'b0;
                end else if (r_state == S_RUN) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == C_GAP_LAST) begin
                    w_cnt_nxt          = '0;
                    w_stage_nxt[r_idx] = 1'b0;
                    if (r_idx == C_IDX_LAST) begin
                        w_state_nxt = S_RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_MMCM_RST;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_stage_nxt = C_ALL_STAGES;
                w_ready_nxt = 1'b0;
            end
        endcase

        w_mmcm_resetn_nxt = (w_state_nxt != S_MMCM_RST);
    end

    // Outputs come straight from flops
    always_comb begin
        mmcm_resetn = r_mmcm_resetn;
        rst_stage   = r_stage;
        ready       = r_ready;
        retry_cnt   = r_retry;
        loss_cnt    = r_loss;
    end

endmodule
